// File: rtl/fp_special_resolve.sv
// fp_special_resolve: front stage of the 32-bit FP ALU.
// Classifies both operands (zero / Inf / NaN), resolves IEEE-754 special
// cases for add/sub/mul/div as a finished early result, and otherwise
// unpacks sign/exponent/mantissa for the normal datapath.
// Two-stage valid/ready pipeline, full rate while out_ready stays high.
// Optional build macro: FP_SPECIAL_STATS_EN adds saturating statistics
// counters (stat_early, stat_nan, stat_dz) of CNT_W bits each.
module fp_special_resolve #(
  parameter logic [31:0] QNAN = 32'h7FC00000
`ifdef FP_SPECIAL_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_early,
  output logic [31:0] out_result,
  output logic        out_dz,
  output logic        out_inv,
  output logic [1:0]  out_op,
  output logic        out_sa,
  output logic        out_sb,
  output logic [7:0]  out_ea,
  output logic [7:0]  out_eb,
  output logic [23:0] out_ma,
  output logic [23:0] out_mb
`ifdef FP_SPECIAL_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_early,
  output logic [CNT_W-1:0] stat_nan,
  output logic [CNT_W-1:0] stat_dz
`endif
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Operand class as {nan, inf, zero}; denormals fall in none of these.
  function automatic logic [2:0] classify(input logic [31:0] x);
    logic exp_ones;
    logic frac_zero;
    exp_ones  = (x[30:23] == 8'hFF);
    frac_zero = (x[22:0] == 23'd0);
    return {exp_ones & ~frac_zero, exp_ones & frac_zero, (x[30:0] == 31'd0)};
  endfunction

  function automatic logic [31:0] signed_inf(input logic s);
    return {s, 8'hFF, 23'd0};
  endfunction

  function automatic logic [31:0] signed_zero(input logic s);
    return {s, 31'd0};
  endfunction

  // Denormals share the minimum exponent of normals, so exp field 0 reads as 1.
  function automatic logic [7:0] unpack_exp(input logic [7:0] e);
    return (e == 8'd0) ? 8'd1 : e;
  endfunction

  function automatic logic [23:0] unpack_man(input logic [31:0] x);
    return {(x[30:23] != 8'd0), x[22:0]};
  endfunction

`ifdef FP_SPECIAL_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction
`endif

  // Handshake / control state
  logic vld_p1_q, vld_p1_d;
  logic vld_p2_q, vld_p2_d;
  logic s2_ready;
  logic s1_adv;
  logic in_fire;

  // Stage-1 data
  logic [31:0] a_p1_q, b_p1_q;
  logic [1:0]  op_p1_q;
  logic [2:0]  cls_a_p1_q, cls_b_p1_q;

  // Stage-2 data (drives the outputs)
  logic        early_p2_q;
  logic [31:0] result_p2_q;
  logic        dz_p2_q, inv_p2_q;
  logic [1:0]  op_p2_q;
  logic        sa_p2_q, sb_p2_q;
  logic [7:0]  ea_p2_q, eb_p2_q;
  logic [23:0] ma_p2_q, mb_p2_q;

  // Resolution of the stage-1 beat
  logic        an, ai, az, bn, bi, bz;
  logic        sa, sb_raw, sb_eff, s_mul;
  logic        early_d, dz_d, inv_d;
  logic [31:0] result_d;

  assign s2_ready = !vld_p2_q || out_ready;
  assign s1_adv   = vld_p1_q && s2_ready;
  assign in_ready = !vld_p1_q || s2_ready;
  assign in_fire  = in_valid && in_ready;

  // Next-state of the two stage valids.
  always_comb begin
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    if (in_fire)        vld_p1_d = 1'b1;
    else if (s1_adv)    vld_p1_d = 1'b0;
    if (s1_adv)         vld_p2_d = 1'b1;
    else if (out_ready) vld_p2_d = 1'b0;
  end

  // Valid registers; reset drops any in-flight beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // ---- Stage 1: capture operands, op and operand classes ----
  always_ff @(posedge clk) begin
    if (in_fire) begin
      a_p1_q     <= in_a;
      b_p1_q     <= in_b;
      op_p1_q    <= in_op;
      cls_a_p1_q <= classify(in_a);
      cls_b_p1_q <= classify(in_b);
    end
  end

  assign {an, ai, az} = cls_a_p1_q;
  assign {bn, bi, bz} = cls_b_p1_q;
  assign sa     = a_p1_q[31];
  assign sb_raw = b_p1_q[31];
  assign sb_eff = sb_raw ^ (op_p1_q == OP_SUB);
  assign s_mul  = sa ^ sb_raw;

  // Special-case resolution, first match wins.
  always_comb begin
    early_d  = 1'b0;
    result_d = 32'd0;
    inv_d    = 1'b0;
    dz_d     = 1'b0;
    if (an || bn) begin
      early_d  = 1'b1;
      result_d = QNAN;
      inv_d    = 1'b1;
    end else begin
      case (op_p1_q)
        OP_ADD, OP_SUB: begin
          if (ai && bi && (sa != sb_eff)) begin
            early_d = 1'b1; result_d = QNAN; inv_d = 1'b1;
          end else if (ai) begin
            early_d = 1'b1; result_d = signed_inf(sa);
          end else if (bi) begin
            early_d = 1'b1; result_d = signed_inf(sb_eff);
          end else if (az && bz) begin
            early_d = 1'b1; result_d = signed_zero(sa & sb_eff);
          end else if (az) begin
            early_d = 1'b1; result_d = {sb_eff, b_p1_q[30:0]};
          end else if (bz) begin
            early_d = 1'b1; result_d = a_p1_q;
          end
        end
        OP_MUL: begin
          if ((ai && bz) || (az && bi)) begin
            early_d = 1'b1; result_d = QNAN; inv_d = 1'b1;
          end else if (ai || bi) begin
            early_d = 1'b1; result_d = signed_inf(s_mul);
          end else if (az || bz) begin
            early_d = 1'b1; result_d = signed_zero(s_mul);
          end
        end
        default: begin
          if ((az && bz) || (ai && bi)) begin
            early_d = 1'b1; result_d = QNAN; inv_d = 1'b1;
          end else if (bz) begin
            early_d = 1'b1; result_d = signed_inf(s_mul); dz_d = 1'b1;
          end else if (ai) begin
            early_d = 1'b1; result_d = signed_inf(s_mul);
          end else if (az || bi) begin
            early_d = 1'b1; result_d = signed_zero(s_mul);
          end
        end
      endcase
    end
  end

  // ---- Stage 2: register resolved result and unpacked fields ----
  always_ff @(posedge clk) begin
    if (rst) begin
      early_p2_q  <= 1'b0;
      result_p2_q <= 32'd0;
      dz_p2_q     <= 1'b0;
      inv_p2_q    <= 1'b0;
      op_p2_q     <= 2'd0;
      sa_p2_q     <= 1'b0;
      sb_p2_q     <= 1'b0;
      ea_p2_q     <= 8'd0;
      eb_p2_q     <= 8'd0;
      ma_p2_q     <= 24'd0;
      mb_p2_q     <= 24'd0;
    end else if (s1_adv) begin
      early_p2_q  <= early_d;
      result_p2_q <= result_d;
      dz_p2_q     <= dz_d;
      inv_p2_q    <= inv_d;
      op_p2_q     <= op_p1_q;
      sa_p2_q     <= sa;
      sb_p2_q     <= sb_eff;
      ea_p2_q     <= unpack_exp(a_p1_q[30:23]);
      eb_p2_q     <= unpack_exp(b_p1_q[30:23]);
      ma_p2_q     <= unpack_man(a_p1_q);
      mb_p2_q     <= unpack_man(b_p1_q);
    end
  end

  assign out_valid  = vld_p2_q;
  assign out_early  = early_p2_q;
  assign out_result = result_p2_q;
  assign out_dz     = dz_p2_q;
  assign out_inv    = inv_p2_q;
  assign out_op     = op_p2_q;
  assign out_sa     = sa_p2_q;
  assign out_sb     = sb_p2_q;
  assign out_ea     = ea_p2_q;
  assign out_eb     = eb_p2_q;
  assign out_ma     = ma_p2_q;
  assign out_mb     = mb_p2_q;

`ifdef FP_SPECIAL_STATS_EN
  logic [CNT_W-1:0] stat_early_q, stat_nan_q, stat_dz_q;

  // Saturating counts of accepted output beats by outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_early_q <= '0;
      stat_nan_q   <= '0;
      stat_dz_q    <= '0;
    end else if (vld_p2_q && out_ready) begin
      if (early_p2_q)          stat_early_q <= sat_inc(stat_early_q);
      if (result_p2_q == QNAN) stat_nan_q   <= sat_inc(stat_nan_q);
      if (dz_p2_q)             stat_dz_q    <= sat_inc(stat_dz_q);
    end
  end

  assign stat_early = stat_early_q;
  assign stat_nan   = stat_nan_q;
  assign stat_dz    = stat_dz_q;
`endif

endmodule

// File: tb/tb_fp_special_resolve.sv
// Directed self-checking bench for fp_special_resolve.
module tb_fp_special_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic        out_early;
  logic [31:0] out_result;
  logic        out_dz, out_inv;
  logic [1:0]  out_op;
  logic        out_sa, out_sb;
  logic [7:0]  out_ea, out_eb;
  logic [23:0] out_ma, out_mb;
`ifdef FP_SPECIAL_STATS_EN
  logic [15:0] stat_early, stat_nan, stat_dz;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_special_resolve dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_early  (out_early),
    .out_result (out_result),
    .out_dz     (out_dz),
    .out_inv    (out_inv),
    .out_op     (out_op),
    .out_sa     (out_sa),
    .out_sb     (out_sb),
    .out_ea     (out_ea),
    .out_eb     (out_eb),
    .out_ma     (out_ma),
    .out_mb     (out_mb)
`ifdef FP_SPECIAL_STATS_EN
    ,
    .stat_early (stat_early),
    .stat_nan   (stat_nan),
    .stat_dz    (stat_dz)
`endif
  );

  // Special-case vectors: a, b, op, expected result / inv / dz (all early)
  localparam int NV = 16;
  localparam logic [31:0] VA [NV] = '{
    32'h7F800000, 32'h7F800000, 32'h40400000, 32'h00000000,
    32'h7F800001, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h80000000, 32'h7F800000, 32'h3F800000, 32'hFF800000,
    32'h00000000, 32'hFF800000, 32'h80000000, 32'h3F800000};
  localparam logic [31:0] VB [NV] = '{
    32'hFF800000, 32'h7F800000, 32'h80000000, 32'hFF800000,
    32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h80000000,
    32'h00000000, 32'hC0000000, 32'h7F800000, 32'h40000000,
    32'h00000000, 32'h7F800000, 32'h40000000, 32'h00000000};
  localparam logic [1:0] VOP [NV] = '{
    2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0,
    2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0};
  localparam logic [31:0] VRES [NV] = '{
    32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000,
    32'h7FC00000, 32'h3F800000, 32'hBF800000, 32'h00000000,
    32'h80000000, 32'hFF800000, 32'h00000000, 32'hFF800000,
    32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h3F800000};
  localparam logic VINV [NV] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic VDZ [NV]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for a single cycle; afterwards it sits in stage 2.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    checks++;
    if ({out_early, out_result, out_dz, out_inv, out_ea, out_ma} !== '0) begin
      errors++; $display("FAIL reset data: got result %h ea %h ma %h expected all zero", out_result, out_ea, out_ma);
    end
  endtask

  task automatic test_normal();
    send_beat(32'h3F800000, 32'h40000000, 2'd0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL normal latency: out_valid got %b expected 1", out_valid); end
    checks++;
    if ({out_early, out_result, out_inv, out_dz} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL normal early: got early %b result %h expected 0 / 00000000", out_early, out_result);
    end
    checks++;
    if ({out_ea, out_ma, out_eb, out_mb} !== {8'h7F, 24'h800000, 8'h80, 24'h800000}) begin
      errors++; $display("FAIL normal fields: got ea %h ma %h eb %h mb %h expected 7f 800000 80 800000", out_ea, out_ma, out_eb, out_mb);
    end
    send_beat(32'h3F800000, 32'h40000000, 2'd1);
    checks++;
    if ({out_op, out_sa, out_sb, out_early} !== {2'd1, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub sign: got op %0d sa %b sb %b early %b expected 1 0 1 0", out_op, out_sa, out_sb, out_early);
    end
    send_beat(32'h00000001, 32'h3F800000, 2'd2);
    checks++;
    if ({out_early, out_ea, out_ma} !== {1'b0, 8'h01, 24'h000001}) begin
      errors++; $display("FAIL denormal: got early %b ea %h ma %h expected 0 01 000001", out_early, out_ea, out_ma);
    end
  endtask

  task automatic test_special();
    for (int i = 0; i < NV; i++) begin
      send_beat(VA[i], VB[i], VOP[i]);
      checks++;
      if ({out_valid, out_early, out_result} !== {1'b1, 1'b1, VRES[i]}) begin
        errors++; $display("FAIL special[%0d] result: got valid %b early %b result %h expected 1 1 %h",
                           i, out_valid, out_early, out_result, VRES[i]);
      end
      checks++;
      if ({out_inv, out_dz} !== {VINV[i], VDZ[i]}) begin
        errors++; $display("FAIL special[%0d] flags: got inv %b dz %b expected %b %b", i, out_inv, out_dz, VINV[i], VDZ[i]);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int rcvd = 0;
    int occ = 0;
    bit saw_full = 1'b0;
    logic exp_rdy;
    for (int c = 0; c < 40 && rcvd < 8; c++) begin
      in_valid  = (sent < 8);
      in_a      = 32'h3F800000 | sent;
      in_b      = 32'h40000000;
      in_op     = 2'd0;
      out_ready = !(c >= 3 && c <= 5);
      #1;
      exp_rdy = (occ < 2) || out_ready;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL b2b in_ready cycle %0d: got %b expected %b", c, in_ready, exp_rdy);
      end
      if (in_ready === 1'b0) saw_full = 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if ({out_early, out_ma} !== {1'b0, 24'h800000 | 24'(rcvd)}) begin
          errors++; $display("FAIL b2b order beat %0d: got early %b ma %h expected 0 %h", rcvd, out_early, out_ma, 24'h800000 | 24'(rcvd));
        end
        rcvd++; occ--;
      end
      if (in_valid && in_ready === 1'b1) begin sent++; occ++; end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (rcvd != 8) begin errors++; $display("FAIL b2b count: got %0d beats expected 8", rcvd); end
    checks++;
    if (!saw_full) begin errors++; $display("FAIL b2b backpressure: in_ready never low, expected low when full"); end
    repeat (3) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b duplicate: out_valid got %b expected 0", out_valid); end
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_a = 32'h7F800001; in_b = 32'h3F800000; in_op = 2'd0; in_valid = 1'b1;
    step();
    in_a = 32'h40400000; in_b = 32'h00000000; in_op = 2'd3;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midflight setup: out_valid got %b expected 1", out_valid); end
    rst = 1'b1;
    step();
    checks++;
    if ({out_valid, in_ready, out_early, out_result} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL midflight reset: got valid %b ready %b early %b result %h expected 0 1 0 00000000",
                         out_valid, in_ready, out_early, out_result);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midflight dropped beat cycle %0d: out_valid got %b expected 0", c, out_valid); end
    end
  endtask

`ifdef FP_SPECIAL_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    send_beat(32'h3F800000, 32'h40000000, 2'd0);
    send_beat(32'h7F800001, 32'h3F800000, 2'd0);
    send_beat(32'h7F800000, 32'hFF800000, 2'd0);
    send_beat(32'h00000000, 32'hFF800000, 2'd2);
    send_beat(32'h40400000, 32'h80000000, 2'd3);
    step();
    checks++;
    if ({stat_nan, stat_dz, stat_early} !== {16'd3, 16'd1, 16'd4}) begin
      errors++; $display("FAIL stats counts: got nan %0d dz %0d early %0d expected 3 1 4", stat_nan, stat_dz, stat_early);
    end
    in_a = 32'h7F800001; in_b = 32'h0; in_op = 2'd0; in_valid = 1'b1;
    repeat (65540) step();
    in_valid = 1'b0;
    repeat (3) step();
    checks++;
    if ({stat_nan, stat_early, stat_dz} !== {16'hFFFF, 16'hFFFF, 16'd1}) begin
      errors++; $display("FAIL stats saturate: got nan %h early %h dz %h expected ffff ffff 0001", stat_nan, stat_early, stat_dz);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_back_to_back();
    test_reset_midflight();
`ifdef FP_SPECIAL_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
